io_out_bank: RTL and testbench

IO_OUT_BANK -- requirements
Module: io_out_bank

---
 rtl/io_out_pkg.sv | 31 +++
 rtl/io_out_channel.sv | 70 +++++++
 rtl/io_out_bank.sv | 76 +++++++
 tb/tb_io_out_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_out_pkg.sv
// Shared register map and select type for the memory-mapped output bank.
package io_out_pkg;

   localparam logic [4:0]  OFS_DATA  = 5'd0;
   localparam logic [4:0]  OFS_SET   = 5'd4;
   localparam logic [4:0]  OFS_CLR   = 5'd8;
   localparam logic [4:0]  OFS_TGL   = 5'd12;
   localparam logic [4:0]  OFS_PULSE = 5'd16;
   localparam int unsigned CH_STRIDE = 32;

   typedef enum logic [2:0] {
      SelNone,
      SelData,
      SelSet,
      SelClr,
      SelTgl,
      SelPulse
   } reg_sel_e;

   function automatic reg_sel_e decode_ofs(input logic [4:0] ofs);
      case (ofs)
         OFS_DATA:  return SelData;
         OFS_SET:   return SelSet;
         OFS_CLR:   return SelClr;
         OFS_TGL:   return SelTgl;
         OFS_PULSE: return SelPulse;
         default:   return SelNone;
      endcase
   endfunction

endpackage

// File: rtl/io_out_channel.sv
// One output channel: data register, timed pulse overlay and registered pin driver.
module io_out_channel
   import io_out_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned PULSE_CYCLES = 1000,
   parameter int unsigned CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  reg_sel_e         sel,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] data_reg,
   output logic [CNT_W-1:0] pulse_cnt,
   output logic [WIDTH-1:0] port
);

   logic [WIDTH-1:0] pulse_mask;
   logic [WIDTH-1:0] data_next;
   logic [WIDTH-1:0] mask_next;
   logic [CNT_W-1:0] cnt_next;
   logic [WIDTH-1:0] port_next;
   logic             pulse_wr;

   always_comb begin
      data_next = data_reg;
      mask_next = pulse_mask;
      cnt_next  = pulse_cnt;
      pulse_wr  = wr_en && (sel == SelPulse);

      if (wr_en) begin
         case (sel)
            SelData: data_next = wdata;
            SelSet:  data_next = data_reg | wdata;
            SelClr:  data_next = data_reg & ~wdata;
            SelTgl:  data_next = data_reg ^ wdata;
            default: ;
         endcase
      end

      // A zero mask cancels; any other mask restarts from a full count.
      if (pulse_wr) begin
         mask_next = wdata;
         cnt_next  = (wdata == '0) ? '0 : CNT_W'(PULSE_CYCLES);
      end else if (pulse_cnt != '0) begin
         cnt_next = pulse_cnt - CNT_W'(1);
         if (cnt_next == '0) begin
            mask_next = '0;
         end
      end

      port_next = data_next | ((cnt_next != '0) ? mask_next : '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg   <= '0;
         pulse_mask <= '0;
         pulse_cnt  <= '0;
         port       <= '0;
      end else begin
         data_reg   <= data_next;
         pulse_mask <= mask_next;
         pulse_cnt  <= cnt_next;
         port       <= port_next;
      end
   end

endmodule

// File: rtl/io_out_bank.sv
// Bank of memory-mapped output channels with SET/CLR/TGL/PULSE access and readback.
module io_out_bank
   import io_out_pkg::*;
#(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned CHANNELS     = 2,
   parameter logic [31:0] BASE_ADDR    = 32'd8,
   parameter int unsigned PULSE_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               bus_in,
   input  logic [31:0]               adress,
   input  logic [1:0]                MemWrite,
   output logic [31:0]               bus_out,
   output logic                      hit,
   output logic [CHANNELS*WIDTH-1:0] IO_port
);

   localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);

   logic [31:0]      rel;
   logic [2:0]       ch_idx;
   reg_sel_e         sel;
   logic             wr;
   logic [WIDTH-1:0] ch_data [CHANNELS];
   logic [CNT_W-1:0] ch_cnt  [CHANNELS];

   // Guard the subtraction so addresses below the base cannot wrap into range.
   always_comb begin
      rel    = adress - BASE_ADDR;
      ch_idx = 3'(rel / CH_STRIDE);
      sel    = SelNone;
      if ((adress >= BASE_ADDR) && (rel < CHANNELS * CH_STRIDE)) begin
         sel = decode_ofs(rel[4:0]);
      end
      hit = (sel != SelNone);
      wr  = hit && (MemWrite != 2'b00);
   end

   always_comb begin
      bus_out = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (hit && (ch_idx == 3'(i))) begin
            if (sel == SelPulse) begin
               bus_out[CNT_W-1:0] = ch_cnt[i];
            end else begin
               bus_out[WIDTH-1:0] = ch_data[i];
            end
         end
      end
   end

   for (genvar n = 0; n < int'(CHANNELS); n++) begin : g_ch
      io_out_channel #(
         .WIDTH        (WIDTH),
         .PULSE_CYCLES (PULSE_CYCLES),
         .CNT_W        (CNT_W)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .wr_en     (wr && (ch_idx == 3'(n))),
         .sel       (sel),
         .wdata     (bus_in[WIDTH-1:0]),
         .data_reg  (ch_data[n]),
         .pulse_cnt (ch_cnt[n]),
         .port      (IO_port[n*WIDTH +: WIDTH])
      );
   end

   if (WIDTH < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^bus_in[31:WIDTH];
   end

endmodule

// File: tb/tb_io_out_bank.sv
// Directed self-checking bench for io_out_bank (2 x 16-bit channels, 4-cycle pulses).
module tb_io_out_bank;

   logic        clk;
   logic        reset;
   logic [31:0] bus_in;
   logic [31:0] adress;
   logic [1:0]  MemWrite;
   logic [31:0] bus_out;
   logic        hit;
   logic [31:0] IO_port;

   int n_cmp;
   int n_bad;

   io_out_bank #(
      .WIDTH        (16),
      .CHANNELS     (2),
      .BASE_ADDR    (32'd8),
      .PULSE_CYCLES (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus_in   (bus_in),
      .adress   (adress),
      .MemWrite (MemWrite),
      .bus_out  (bus_out),
      .hit      (hit),
      .IO_port  (IO_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] we);
      @(negedge clk);
      adress   = a;
      bus_in   = d;
      MemWrite = we;
      @(posedge clk);
      #1;
      MemWrite = 2'b00;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      adress = 32'd8;
      #1;
      n_cmp++;
      if (IO_port !== 32'h0) begin
         $display("FAIL reset_port got %h want %h", IO_port, 32'h0);
         n_bad++;
      end
      n_cmp++;
      if (bus_out !== 32'h0 || hit !== 1'b1) begin
         $display("FAIL reset_readback got %h/%b want 0/1", bus_out, hit);
         n_bad++;
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_data();
      do_write(32'd8, 32'h0000A5A5, 2'b10);
      n_cmp++;
      if (IO_port !== 32'h0000A5A5) begin
         $display("FAIL data_ch0 got %h want %h", IO_port, 32'h0000A5A5);
         n_bad++;
      end
      n_cmp++;
      if (bus_out !== 32'h0000A5A5 || hit !== 1'b1) begin
         $display("FAIL data_readback got %h/%b want %h/1", bus_out, hit, 32'h0000A5A5);
         n_bad++;
      end
   endtask

   task automatic test_set_clr_tgl();
      logic [31:0] addrs [4] = '{32'd40, 32'd44, 32'd48, 32'd52};
      logic [15:0] vals  [4] = '{16'h00F0, 16'h000F, 16'h0030, 16'hFFFF};
      logic [15:0] exps  [4] = '{16'h00F0, 16'h00FF, 16'h00CF, 16'hFF30};
      for (int i = 0; i < 4; i++) begin
         do_write(addrs[i], {16'h0, vals[i]}, 2'b01);
         n_cmp++;
         if (IO_port !== {exps[i], 16'hA5A5}) begin
            $display("FAIL sct_%0d got %h want %h", i, IO_port, {exps[i], 16'hA5A5});
            n_bad++;
         end
      end
      n_cmp++;
      if (bus_out !== 32'h0000FF30) begin
         $display("FAIL sct_readback got %h want %h", bus_out, 32'h0000FF30);
         n_bad++;
      end
   endtask

   task automatic test_pulse();
      logic [15:0] exp_bits;
      do_write(32'd8, 32'h0, 2'b01);
      do_write(32'd24, 32'h1, 2'b01);
      n_cmp++;
      if (IO_port !== 32'hFF30_0001 || bus_out !== 32'd4) begin
         $display("FAIL pulse_start got %h/%0d want %h/4", IO_port, bus_out, 32'hFF30_0001);
         n_bad++;
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         exp_bits = (k < 4) ? 16'h0001 : 16'h0000;
         n_cmp++;
         if (IO_port !== {16'hFF30, exp_bits} || bus_out !== 32'(4 - k)) begin
            $display("FAIL pulse_cyc%0d got %h/%0d want %h/%0d", k, IO_port, bus_out,
                     {16'hFF30, exp_bits}, 4 - k);
            n_bad++;
         end
      end
   endtask

   task automatic test_restart_cancel();
      logic [15:0] exp_bits;
      do_write(32'd24, 32'h1, 2'b01);
      step();
      step();
      do_write(32'd24, 32'h2, 2'b01);
      n_cmp++;
      if (IO_port[15:0] !== 16'h0002 || bus_out !== 32'd4) begin
         $display("FAIL restart got %h/%0d want 0002/4", IO_port[15:0], bus_out);
         n_bad++;
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         exp_bits = (k < 4) ? 16'h0002 : 16'h0000;
         n_cmp++;
         if (IO_port[15:0] !== exp_bits) begin
            $display("FAIL restart_cyc%0d got %h want %h", k, IO_port[15:0], exp_bits);
            n_bad++;
         end
      end
      do_write(32'd24, 32'h2, 2'b01);
      do_write(32'd8, 32'h8000, 2'b01);
      n_cmp++;
      if (IO_port[15:0] !== 16'h8002) begin
         $display("FAIL data_during_pulse got %h want %h", IO_port[15:0], 16'h8002);
         n_bad++;
      end
      do_write(32'd24, 32'h0, 2'b01);
      n_cmp++;
      if (IO_port !== 32'hFF30_8000 || bus_out !== 32'd0) begin
         $display("FAIL cancel got %h/%0d want %h/0", IO_port, bus_out, 32'hFF30_8000);
         n_bad++;
      end
      adress = 32'd8;
      #1;
      n_cmp++;
      if (bus_out !== 32'h0000_8000) begin
         $display("FAIL pulse_keeps_data got %h want %h", bus_out, 32'h0000_8000);
         n_bad++;
      end
   endtask

   task automatic test_undecoded();
      logic [31:0] bad_addrs [5] = '{32'd72, 32'd28, 32'd4, 32'd10, 32'd60};
      for (int i = 0; i < 5; i++) begin
         do_write(bad_addrs[i], 32'hFFFF_FFFF, 2'b11);
         n_cmp++;
         if (IO_port !== 32'hFF30_8000 || hit !== 1'b0 || bus_out !== 32'h0) begin
            $display("FAIL undecoded_%0d got %h/%b/%h want %h/0/0", bad_addrs[i], IO_port, hit,
                     bus_out, 32'hFF30_8000);
            n_bad++;
         end
      end
      // Top of the decoded window: ch1 PULSE readback, idle counter.
      adress = 32'd56;
      #1;
      n_cmp++;
      if (hit !== 1'b1 || bus_out !== 32'h0) begin
         $display("FAIL edge_hit got %b/%h want 1/0", hit, bus_out);
         n_bad++;
      end
   endtask

   task automatic test_reset_mid_pulse();
      do_write(32'd8, 32'hFFFF, 2'b01);
      do_write(32'd24, 32'h00FF, 2'b01);
      step();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (IO_port !== 32'h0) begin
         $display("FAIL async_reset got %h want %h", IO_port, 32'h0);
         n_bad++;
      end
      adress   = 32'd8;
      bus_in   = 32'h1234;
      MemWrite = 2'b01;
      step();
      MemWrite = 2'b00;
      n_cmp++;
      if (IO_port !== 32'h0 || bus_out !== 32'h0) begin
         $display("FAIL write_in_reset got %h/%h want 0/0", IO_port, bus_out);
         n_bad++;
      end
      @(negedge clk);
      reset  = 1'b0;
      adress = 32'd24;
      for (int k = 0; k < 5; k++) begin
         step();
         n_cmp++;
         if (IO_port !== 32'h0 || bus_out !== 32'h0) begin
            $display("FAIL post_reset_%0d got %h/%0d want 0/0", k, IO_port, bus_out);
            n_bad++;
         end
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      reset    = 1'b1;
      bus_in   = '0;
      adress   = '0;
      MemWrite = 2'b00;
      #12;
      test_reset();
      test_data();
      test_set_clr_tgl();
      test_pulse();
      test_restart_cancel();
      test_undecoded();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
